mdr_mem_ctrl: RTL and testbench

Parametrised memory data register with a built-in memory handshake controller. It is the successor to the plain MDR. It holds the CPU-side data register and drives the bus-visible copy. It also runs read and write transactions against a memory port with a req/ack handshake, and supports sub-word (byte/half/word/full) access with lane alignment and sign or zero extension. Alignment faults and timeouts are reported to the control unit. It sits between the datapath bus (BusMuxOut/BusMuxIn) and the memory subsystem.

---
 rtl/mdr_pkg.sv | 30 +++
 rtl/mdr_lane_align.sv | 68 ++++++
 rtl/mdr_mem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mdr_mem_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
// Shared types and helpers for the memory data register / handshake controller.
package mdr_pkg;

    // Access size encodings as presented on the size port
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_FULL = 2'b11
    } size_e;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_WR_WAIT = 2'b10,
        ST_FAULT   = 2'b11
    } state_e;

    // Bytes touched by an access; a full access covers every lane of the word
    function automatic int unsigned size_bytes(input size_e sz, input int unsigned nb);
        case (sz)
            SZ_BYTE: return 1;
            SZ_HALF: return 2;
            SZ_WORD: return 4;
            default: return nb;
        endcase
    endfunction

endpackage

// File: rtl/mdr_lane_align.sv
// Lane steering: read extract/extend, write replicate, byte enables, misalignment.
module mdr_lane_align
    import mdr_pkg::*;
#(
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned NB     = DATA_W / 8,
    localparam int unsigned LB     = $clog2(NB)
) (
    input  logic [1:0]        i_size,
    input  logic              i_sext,
    input  logic [LB-1:0]     i_off,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [DATA_W-1:0] i_wsrc,
    output logic [DATA_W-1:0] o_rd_ext,
    output logic [DATA_W-1:0] o_wdata,
    output logic [NB-1:0]     o_be,
    output logic              o_misalign
);

    size_e             w_sz;
    logic [DATA_W-1:0] w_shift;
    logic [LB-1:0]     w_amask;
    logic [NB-1:0]     w_sz_be;

    assign w_sz    = size_e'(i_size);
    assign w_shift = i_rdata >> {i_off, 3'b000};
    assign w_amask = LB'(size_bytes(w_sz, NB) - 1);

    // Offset must be a multiple of the access size
    assign o_misalign = |(i_off & w_amask);
    assign o_be       = w_sz_be << i_off;

    // Unshifted lane mask for the access size
    always_comb begin
        w_sz_be = '1;
        case (w_sz)
            SZ_BYTE: w_sz_be = NB'(1);
            SZ_HALF: w_sz_be = NB'(3);
            SZ_WORD: w_sz_be = NB'(15);
            default: w_sz_be = '1;
        endcase
    end

    // Read-side extension and write-side lane replication
    always_comb begin
        o_rd_ext = w_shift;
        o_wdata  = i_wsrc;
        case (w_sz)
            SZ_BYTE: begin
                o_rd_ext = i_sext ? DATA_W'($signed(w_shift[7:0])) : DATA_W'(w_shift[7:0]);
                o_wdata  = {NB{i_wsrc[7:0]}};
            end
            SZ_HALF: begin
                o_rd_ext = i_sext ? DATA_W'($signed(w_shift[15:0])) : DATA_W'(w_shift[15:0]);
                o_wdata  = {(NB/2){i_wsrc[15:0]}};
            end
            SZ_WORD: begin
                o_rd_ext = i_sext ? DATA_W'($signed(w_shift[31:0])) : DATA_W'(w_shift[31:0]);
                o_wdata  = {(NB/4){i_wsrc[31:0]}};
            end
            default: begin
                o_rd_ext = w_shift;
                o_wdata  = i_wsrc;
            end
        endcase
    end

endmodule

// File: rtl/mdr_mem_ctrl.sv
// Memory data register with req/ack memory handshake, sub-word access and fault reporting.
module mdr_mem_ctrl
    import mdr_pkg::*;
#(
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned TIMEOUT = 15,
    localparam int unsigned NB      = DATA_W / 8,
    localparam int unsigned LB      = $clog2(NB),
    localparam int unsigned CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MDRin,
    input  logic              mem_rd_start,
    input  logic              mem_wr_start,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [LB-1:0]     addr_lo,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [NB-1:0]     mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] MDR_q,
    output logic [DATA_W-1:0] BusMuxIn_MDR,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            r_state, w_state_nxt;
    logic              r_req, w_req_nxt;
    logic              r_we, w_we_nxt;
    logic [NB-1:0]     r_be, w_be_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_mdr, w_mdr_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [1:0]        r_size, w_size_nxt;
    logic              r_sext, w_sext_nxt;
    logic [LB-1:0]     r_off, w_off_nxt;

    logic [1:0]        w_al_size;
    logic [LB-1:0]     w_al_off;
    logic [DATA_W-1:0] w_rd_ext;
    logic [DATA_W-1:0] w_wdata;
    logic [NB-1:0]     w_be;
    logic              w_misalign;
    logic              w_tmo;

    // Live request fields are steered while idle, latched ones during a transaction
    assign w_al_size = (r_state == ST_IDLE) ? size    : r_size;
    assign w_al_off  = (r_state == ST_IDLE) ? addr_lo : r_off;

    // Timeout fires on the TIMEOUT-th consecutive ack-low wait edge
    assign w_tmo = (TIMEOUT != 0) && (32'(r_cnt) == TIMEOUT - 1);

    mdr_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_size     (w_al_size),
        .i_sext     (r_sext),
        .i_off      (w_al_off),
        .i_rdata    (mem_rdata),
        .i_wsrc     (r_mdr),
        .o_rd_ext   (w_rd_ext),
        .o_wdata    (w_wdata),
        .o_be       (w_be),
        .o_misalign (w_misalign)
    );

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_be_nxt    = r_be;
        w_wdata_nxt = r_wdata;
        w_mdr_nxt   = r_mdr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;
        w_size_nxt  = r_size;
        w_sext_nxt  = r_sext;
        w_off_nxt   = r_off;

        case (r_state)
            ST_IDLE: begin
                if (mem_rd_start || mem_wr_start) begin
                    w_size_nxt = size;
                    w_sext_nxt = sext;
                    w_off_nxt  = addr_lo;
                    w_err_nxt  = 1'b0;
                    w_cnt_nxt  = '0;
                    w_busy_nxt = 1'b1;
                    if (w_misalign) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_state_nxt = mem_rd_start ? ST_RD_WAIT : ST_WR_WAIT;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = ~mem_rd_start;
                        w_be_nxt    = w_be;
                        w_wdata_nxt = mem_rd_start ? '0 : w_wdata;
                    end
                end else if (MDRin) begin
                    w_mdr_nxt = BusMuxOut;
                end
            end
            ST_RD_WAIT, ST_WR_WAIT: begin
                if (mem_ack || w_tmo) begin
                    w_state_nxt = ST_IDLE;
                    w_req_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_be_nxt    = '0;
                    w_wdata_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = ~mem_ack;
                    if (mem_ack && (r_state == ST_RD_WAIT)) begin
                        w_mdr_nxt = w_rd_ext;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_FAULT: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_err_nxt   = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_mdr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
            r_off   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_be    <= w_be_nxt;
            r_wdata <= w_wdata_nxt;
            r_mdr   <= w_mdr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
            r_size  <= w_size_nxt;
            r_sext  <= w_sext_nxt;
            r_off   <= w_off_nxt;
        end
    end

    assign mem_req      = r_req;
    assign mem_we       = r_we;
    assign mem_be       = r_be;
    assign mem_wdata    = r_wdata;
    assign MDR_q        = r_mdr;
    assign BusMuxIn_MDR = r_mdr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_mdr_mem_ctrl.sv
// Self-checking bench for mdr_mem_ctrl (DATA_W=32, TIMEOUT=4).
module tb_mdr_mem_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        MDRin;
    logic        mem_rd_start;
    logic        mem_wr_start;
    logic [1:0]  size;
    logic        sext;
    logic [1:0]  addr_lo;
    logic [31:0] BusMuxOut;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] MDR_q;
    logic [31:0] BusMuxIn_MDR;
    logic        busy;
    logic        done;
    logic        err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_mdr    = '0;
    bit          m_err    = 1'b0;

    mdr_mem_ctrl #(
        .DATA_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .MDRin        (MDRin),
        .mem_rd_start (mem_rd_start),
        .mem_wr_start (mem_wr_start),
        .size         (size),
        .sext         (sext),
        .addr_lo      (addr_lo),
        .BusMuxOut    (BusMuxOut),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .MDR_q        (MDR_q),
        .BusMuxIn_MDR (BusMuxIn_MDR),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sz_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Reference read: pick nb bytes starting at byte off, then extend
    function automatic logic [31:0] ref_read(input logic [31:0] rd, input int nb, input bit sx, input int off);
        longint unsigned m;
        longint unsigned v;
        m = (64'd1 << (8 * nb)) - 1;
        v = (64'(rd) >> (8 * off)) & m;
        if (sx && (((v >> (8 * nb - 1)) & 1) == 1)) v = v | ~m;
        return 32'(v);
    endfunction

    // Reference write data: lane i carries source byte (i mod nb)
    function automatic logic [31:0] ref_wdata(input logic [31:0] src, input int nb);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r = r | (((src >> (8 * (i % nb))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    // One transaction: start, waits ack-low cycles, then ack (or timeout)
    task automatic txn(input bit rd, input logic [1:0] sz, input bit sx, input logic [1:0] off,
                       input logic [31:0] rdata, input int waits,
                       output logic [3:0] s_be, output logic [31:0] s_wd);
        int          nb;
        bit          mis;
        bit          fin;
        bit          e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        nb    = sz_bytes(sz);
        mis   = (int'(off) % nb) != 0;
        e_be  = 4'(((1 << nb) - 1) << off);
        e_wd  = ref_wdata(m_mdr, nb);
        e_err = 1'b0;
        mem_rd_start = rd;
        mem_wr_start = !rd;
        size = sz; sext = sx; addr_lo = off;
        mem_ack = 1'b0; mem_rdata = $urandom;
        tick();
        mem_rd_start = 1'b0;
        mem_wr_start = 1'b0;
        s_be = mem_be;
        s_wd = mem_wdata;
        check("start_err", err, 0);
        check("start_done", done, 0);
        if (mis) begin
            check("flt_req", mem_req, 0);
            tick();
            check("flt_done", done, 1);
            check("flt_err", err, 1);
            check("flt_busy", busy, 0);
            check("flt_mdr", MDR_q, m_mdr);
            e_err = 1'b1;
        end else begin
            check("req", mem_req, 1);
            check("busy", busy, 1);
            check("we", mem_we, !rd);
            check("be", mem_be, e_be);
            if (!rd) check("wdata", mem_wdata, e_wd);
            fin = 1'b0;
            for (int c = 1; c <= TMO && !fin; c++) begin
                mem_ack   = (c > waits);
                mem_rdata = mem_ack ? rdata : $urandom;
                MDRin     = 1'($urandom_range(0, 1));
                BusMuxOut = $urandom;
                tick();
                MDRin = 1'b0;
                if (mem_ack) begin
                    if (rd) m_mdr = ref_read(rdata, nb, sx, int'(off));
                    check("ok_done", done, 1);
                    check("ok_err", err, 0);
                    check("ok_req", mem_req, 0);
                    check("ok_busy", busy, 0);
                    check("ok_mdr", MDR_q, m_mdr);
                    fin = 1'b1;
                end else if (c == TMO) begin
                    check("tmo_done", done, 1);
                    check("tmo_err", err, 1);
                    check("tmo_req", mem_req, 0);
                    check("tmo_busy", busy, 0);
                    check("tmo_mdr", MDR_q, m_mdr);
                    e_err = 1'b1;
                    fin = 1'b1;
                end else begin
                    check("wait_req", mem_req, 1);
                    check("wait_done", done, 0);
                    check("hold_we", mem_we, !rd);
                    check("hold_be", mem_be, e_be);
                    if (!rd) check("hold_wd", mem_wdata, e_wd);
                    check("wait_mdr", MDR_q, m_mdr);
                end
            end
            mem_ack = 1'b0;
        end
        tick();
        check("post_done", done, 0);
        check("post_err", err, e_err);
        check("post_req", mem_req, 0);
        m_err = e_err;
    endtask

    // Bound on total run time
    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  s_be;
        logic [31:0] s_wd;

        clr = 1'b1; MDRin = 1'b0; mem_rd_start = 1'b0; mem_wr_start = 1'b0;
        size = 2'b00; sext = 1'b0; addr_lo = 2'd0; BusMuxOut = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        tick();
        tick();
        check("rst_mdr", MDR_q, 0);
        check("rst_bus", BusMuxIn_MDR, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_be", mem_be, 0);
        check("rst_wd", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        clr = 1'b0;

        // clr in the middle of a read
        MDRin = 1'b1; BusMuxOut = 32'h1234_5678;
        tick();
        MDRin = 1'b0;
        check("ld_mdr", MDR_q, 32'h1234_5678);
        mem_rd_start = 1'b1; size = 2'b10; addr_lo = 2'd0;
        tick();
        mem_rd_start = 1'b0;
        check("clr_pre_req", mem_req, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_mdr", MDR_q, 0);
        check("clr_req", mem_req, 0);
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        tick();
        check("clr_nodone", done, 0);
        m_mdr = '0;

        // signed byte read at offset 3, ack on the third edge
        txn(1'b1, 2'b00, 1'b1, 2'd3, 32'h80AB_CD11, 2, s_be, s_wd);
        check("sbyte_mdr", MDR_q, 32'hFFFF_FF80);
        check("sbyte_be", s_be, 4'b1000);

        // half write at offset 2
        MDRin = 1'b1; BusMuxOut = 32'h0000_BEEF;
        tick();
        MDRin = 1'b0;
        m_mdr = 32'h0000_BEEF;
        txn(1'b0, 2'b01, 1'b0, 2'd2, 32'h0, 2, s_be, s_wd);
        check("hw_be", s_be, 4'b1100);
        check("hw_wd", s_wd, 32'hBEEF_BEEF);
        check("hw_mdr", MDR_q, 32'h0000_BEEF);

        // misaligned word; err holds across an MDRin load
        txn(1'b1, 2'b10, 1'b0, 2'd1, 32'hDEAD_BEEF, 0, s_be, s_wd);
        MDRin = 1'b1; BusMuxOut = 32'hA5A5_0F0F;
        tick();
        MDRin = 1'b0;
        m_mdr = 32'hA5A5_0F0F;
        check("flt_hold_err", err, 1);
        check("flt_ld_mdr", MDR_q, m_mdr);

        // timeout, then ack exactly on the timeout edge
        txn(1'b1, 2'b10, 1'b0, 2'd0, 32'h1111_2222, TMO, s_be, s_wd);
        txn(1'b1, 2'b10, 1'b0, 2'd0, 32'h3333_4444, TMO - 1, s_be, s_wd);

        // back-to-back with ack tied high; MDRin while busy is ignored
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_1234;
        mem_rd_start = 1'b1; size = 2'b10; addr_lo = 2'd0; sext = 1'b0;
        tick();
        mem_rd_start = 1'b0;
        check("b2b_rd_req", mem_req, 1);
        tick();
        check("b2b_rd_done", done, 1);
        check("b2b_rd_mdr", MDR_q, 32'hCAFE_1234);
        m_mdr = 32'hCAFE_1234;
        mem_wr_start = 1'b1; size = 2'b11; addr_lo = 2'd0;
        MDRin = 1'b1; BusMuxOut = 32'h0BAD_0BAD;
        tick();
        mem_wr_start = 1'b0;
        check("b2b_wr_req", mem_req, 1);
        check("b2b_wr_we", mem_we, 1);
        check("b2b_wr_be", mem_be, 4'hF);
        check("b2b_wr_wd", mem_wdata, 32'hCAFE_1234);
        check("b2b_wr_nodone", done, 0);
        tick();
        MDRin = 1'b0;
        check("b2b_wr_done", done, 1);
        check("b2b_wr_err", err, 0);
        check("b2b_mdr_kept", MDR_q, 32'hCAFE_1234);
        mem_ack = 1'b0;
        tick();
        check("b2b_done_low", done, 0);
        m_err = 1'b0;

        // randomized transactions against the reference model
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                MDRin = 1'b1; BusMuxOut = $urandom;
                tick();
                MDRin = 1'b0;
                m_mdr = BusMuxOut;
                check("rnd_ld_mdr", MDR_q, m_mdr);
                check("rnd_ld_err", err, m_err);
            end
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 5), s_be, s_wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
